// File: rtl/countdown_alarm_ctrl.sv
//------------------------------------------------------------------------------
// Module     : countdown_alarm_ctrl
// Description: Seconds countdown timer. A prescaler divides clk down to a
//              one-second tick; the loaded seconds value counts down to zero,
//              after which blink_en is held high for the LED blink stage until
//              the alarm is acknowledged or cleared.
//              Optional build macro: ALARM_TIMEOUT_EN -- when defined, the
//              alarm returns to IDLE on its own after ALARM_SECS ticks.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module countdown_alarm_ctrl #(
  parameter int DIV        = 100_000_000,
  parameter int W          = 12,
  parameter int ALARM_SECS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  input  logic         ack,
  output logic         tick,
  output logic         blink_en,
  output logic [W-1:0] remaining,
  output logic [1:0]   state,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] ALARM = 2'd3;

  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic          wrap;
  logic [PW-1:0] pre_next;

  // Prescaler terminal count and its wrapped successor.
  assign wrap     = (prescaler == PRE_LAST);
  assign pre_next = wrap ? '0 : prescaler + PW'(1);

`ifdef ALARM_TIMEOUT_EN
  localparam int            AW       = $clog2(ALARM_SECS + 1);
  localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_SECS - 1);
  logic [AW-1:0] alarm_cnt;
`else
  // Timeout length only matters when the auto-timeout is built in.
  logic unused_alarm_secs;
  assign unused_alarm_secs = ^ALARM_SECS;
`endif

  // Control FSM, prescaler, seconds counter and tick pulse.
  // Strobe priority: clear > ack > load > pause > start, where a strobe that
  // does not apply in the current state is skipped. A tick event is only
  // published when the block stays in RUN/ALARM, so tick never shows in
  // IDLE or PAUSE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      alarm_cnt <= '0;
`endif
    end else begin
      tick <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        remaining <= '0;
        prescaler <= '0;
`ifdef ALARM_TIMEOUT_EN
        alarm_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              remaining <= load_val;
            end else if (start && (remaining != '0)) begin
              state     <= RUN;
              prescaler <= '0;
            end
          end

          RUN: begin
            // Pausing freezes the prescaler, discarding a coincident tick.
            if (pause) begin
              state <= PAUSE;
            end else begin
              prescaler <= pre_next;
              if (wrap) begin
                tick <= 1'b1;
                if (remaining > W'(1)) begin
                  remaining <= remaining - W'(1);
                end else begin
                  remaining <= '0;
                  state     <= ALARM;
`ifdef ALARM_TIMEOUT_EN
                  alarm_cnt <= '0;
`endif
                end
              end
            end
          end

          PAUSE: begin
            // Resume keeps the held prescaler phase.
            if (load) begin
              remaining <= load_val;
            end else if (start) begin
              state <= RUN;
            end
          end

          ALARM: begin
            if (ack) begin
              state <= IDLE;
            end else begin
              prescaler <= pre_next;
              if (wrap) begin
`ifdef ALARM_TIMEOUT_EN
                if (alarm_cnt == ALM_LAST) begin
                  state     <= IDLE;
                  alarm_cnt <= '0;
                end else begin
                  alarm_cnt <= alarm_cnt + AW'(1);
                  tick      <= 1'b1;
                end
`else
                tick <= 1'b1;
`endif
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status outputs decoded directly from the state register.
  assign blink_en = (state == ALARM);
  assign busy     = (state == RUN) || (state == PAUSE);

endmodule

`default_nettype wire

// File: doc/countdown_alarm_ctrl.md
# countdown_alarm_ctrl

Seconds countdown timer feeding the LED blink stage: prescales the system clock to a one-second tick, counts a loaded value down to zero, then holds `blink_en` high for the blink stage's `enable` input until acknowledged or timed out. It sits directly upstream of the LED blinker and shares its clock domain. `tick` is also exported as the blinker's one-pulse-per-second timebase.

## Interface
- `DIV`, 100_000_000, clk cycles per one-second tick (≥2)
- `W`, 12, width of the seconds counter
- `ALARM_SECS`, 10, alarm auto-timeout in ticks (used only with `ALARM_TIMEOUT_EN`, ≥1)

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `load`  in  1  one-cycle strobe: capture `load_val` into `remaining`
- `load_val`  in  W  countdown value in seconds
- `start`  in  1  start from IDLE, or resume from PAUSE
- `pause`  in  1  freeze countdown (RUN→PAUSE)
- `clear`  in  1  abort to IDLE, zero everything
- `ack`  in  1  acknowledge alarm (ALARM→IDLE)
- `tick`  out  1  one-cycle pulse per elapsed second (RUN/ALARM only)
- `blink_en`  out  1  high while in ALARM; drives blinker `enable`
- `remaining`  out  W  seconds left
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3
- `busy`  out  1  high when state is RUN or PAUSE

## Operation
- Reset: state IDLE, `remaining`=0, prescaler=0, alarm counter=0, `tick`=0, `blink_en`=0, `busy`=0.
- Control priority when several strobes are high in one cycle: clear > ack > load > pause > start. Only the highest-priority *applicable* strobe acts.
- clear (any state): →IDLE, `remaining`=0, prescaler=0, alarm counter=0.
- load: accepted in IDLE and PAUSE only; `remaining`←`load_val`. Ignored in RUN/ALARM.
- IDLE: start with `remaining`≠0 → RUN, prescaler←0. start with `remaining`=0 is ignored.
- RUN: prescaler increments each cycle. When it equals DIV-1 it wraps to 0 and a tick event occurs:
  - `remaining`>1: decrement.
  - `remaining`=1: set to 0, →ALARM, alarm counter←0.
- RUN + pause → PAUSE. Prescaler and `remaining` hold. A tick event in the same cycle is discarded.
- PAUSE + start → RUN. Prescaler resumes from its held value, not from 0.
- ALARM: prescaler keeps running and ticks keep pulsing. `remaining` stays 0. ack → IDLE. start and pause are ignored.
- Counters wrap only as stated; `remaining` never underflows below 0.

## Timing
- All outputs are registered. Strobes are sampled on the rising edge of `clk`.
- `start` accepted at edge k → `state`=RUN in cycle k+1 with prescaler=0.
- The first tick event is evaluated at edge k+DIV. `tick`=1 and the updated `remaining` are both visible in cycle k+DIV+1, then every DIV cycles after that.
- After a load of N, the alarm is reached N·DIV cycles after start (with no pause): `state`=ALARM and `blink_en`=1 in the same cycle as the Nth `tick`.
- `tick` is exactly one cycle wide. It is never asserted in IDLE or PAUSE.
- `blink_en` falls in the cycle after ack or clear is sampled, or after the timeout.
- `rst` mid-countdown overrides everything: all outputs return to reset values in the next cycle.

## Configuration
- `ALARM_TIMEOUT_EN` defined: in ALARM, the alarm counter increments on each tick event. When it reaches ALARM_SECS, the block moves to IDLE on that same edge, unless ack or clear fires first with equal effect. `blink_en` is then high for exactly ALARM_SECS·DIV cycles, measured from alarm entry.
- Not defined: there is no alarm counter, and ALARM persists until ack or clear.

## Test plan
Test parameters: DIV=4, W=4, ALARM_SECS=3.
- Reset, then load 3, then start → `tick` appears in cycles start+5, +9, +13; `remaining` reads 2, 1, 0; ALARM and `blink_en`=1 at cycle +13.
- Load 5, start, pause after 2 ticks, wait 20 cycles, then start → `remaining` holds at 3 with no `tick` during the pause. Countdown resumes with the prescaler continuing from its held value, and ALARM is reached after 3 more ticks.
- In ALARM, pulse ack → IDLE next cycle and `blink_en`=0. With `ALARM_TIMEOUT_EN`, no ack → IDLE after 3 ticks (12 cycles).
- Start with `remaining`=0 → stays IDLE and no `tick`. Load during RUN → `remaining` unchanged.
- Assert clear and ack together in ALARM, and load and start together in IDLE → clear wins (all zero). load wins, leaving the block in IDLE with the new value, and a later start is accepted.
- Assert `rst` mid-RUN with `remaining`=7 → next cycle all outputs are 0 and state is IDLE.
